// File: rtl/uart_reg_pkg.sv
// Shared types and constants for the UART register responder: packet bytes,
// parser/reply state encodings and a saturating counter helper.
package uart_reg_pkg;

  localparam logic [7:0] SYNC_BYTE      = 8'h55;
  localparam logic [7:0] REPLY_BYTE     = 8'hAA;
  localparam logic [7:0] CMD_READ       = 8'h01;
  localparam logic [7:0] CMD_WRITE      = 8'h02;
  localparam int         TIMEOUT_CYCLES = 50000;

  typedef enum logic [2:0] {
    P_IDLE   = 3'd0,
    P_CMD    = 3'd1,
    P_ADDR   = 3'd2,
    P_DATA   = 3'd3,
    P_EXEC   = 3'd4,
    P_RDWAIT = 3'd5,
    P_REPLY  = 3'd6
  } parser_state_t;

  typedef enum logic [1:0] {
    R_IDLE      = 2'd0,
    R_WAIT_IDLE = 2'd1,
    R_WAIT_HIGH = 2'd2
  } reply_state_t;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/uart_reply_sender.sv
// Sends three bytes to the UART transmitter, one handshake per byte
// (wait busy low, raise send, wait busy high, drop send); pulses done at the end.
module uart_reply_sender
  import uart_reg_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] byte0,
  input  logic [7:0] byte1,
  input  logic [7:0] byte2,
  input  logic       tx_busy,
  output logic [7:0] tx_data,
  output logic       tx_send,
  output logic       done
);

  reply_state_t state_q, state_d;
  logic [1:0]   idx_q, idx_d;
  logic [7:0]   b1_q, b1_d, b2_q, b2_d, tx_data_q, tx_data_d;
  logic         send_q, send_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= R_IDLE;
      idx_q     <= 2'd0;
      b1_q      <= 8'h00;
      b2_q      <= 8'h00;
      tx_data_q <= 8'h00;
      send_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      b1_q      <= b1_d;
      b2_q      <= b2_d;
      tx_data_q <= tx_data_d;
      send_q    <= send_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    b1_d      = b1_q;
    b2_d      = b2_q;
    tx_data_d = tx_data_q;
    send_d    = send_q;
    done      = 1'b0;
    case (state_q)
      R_IDLE: begin
        if (start) begin
          // Skip the wait state when the line is already free to save a cycle
          b1_d      = byte1;
          b2_d      = byte2;
          idx_d     = 2'd0;
          tx_data_d = byte0;
          send_d    = !tx_busy;
          state_d   = tx_busy ? R_WAIT_IDLE : R_WAIT_HIGH;
        end else begin
          send_d = 1'b0;
        end
      end
      R_WAIT_IDLE: begin
        if (!tx_busy) begin
          send_d  = 1'b1;
          state_d = R_WAIT_HIGH;
        end else begin
          send_d = 1'b0;
        end
      end
      R_WAIT_HIGH: begin
        if (tx_busy) begin
          send_d = 1'b0;
          if (idx_q == 2'd2) begin
            done    = 1'b1;
            state_d = R_IDLE;
          end else begin
            idx_d     = idx_q + 2'd1;
            tx_data_d = (idx_q == 2'd0) ? b1_q : b2_q;
            state_d   = R_WAIT_IDLE;
          end
        end else begin
          send_d = 1'b1;
        end
      end
      default: begin
        send_d  = 1'b0;
        state_d = R_IDLE;
      end
    endcase
  end

  assign tx_data = tx_data_q;
  assign tx_send = send_q;

endmodule

// File: rtl/uart_reg_responder.sv
// Host packet parser: decodes {55, cmd, addr[, data]}, performs one register
// read or write, and returns {AA, addr, data} through the reply sender.
module uart_reg_responder
  import uart_reg_pkg::*;
(
  input  logic       ipClk,
  input  logic       ipReset,
  input  logic [7:0] ipRxData,
  input  logic       ipRxValid,
  output logic [7:0] opTxData,
  output logic       opTxSend,
  input  logic       ipTxBusy,
  output logic [7:0] opRegAddr,
  output logic [7:0] opRegWrData,
  output logic       opRegWrEnable,
  output logic       opRegRdEnable,
  input  logic [7:0] ipRegRdData,
  output logic       opBusy,
  output logic [7:0] opErrorCount
);

  localparam int               TMO_W    = $clog2(TIMEOUT_CYCLES);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

  parser_state_t    state_q, state_d;
  logic             is_write_q, is_write_d;
  logic [7:0]       addr_q, addr_d, wdata_q, wdata_d, err_q, err_d;
  logic             wr_en_q, wr_en_d, rd_en_q, rd_en_d, busy_q, busy_d;
  logic [TMO_W-1:0] tmo_q, tmo_d;
  logic             start_s, done_s, in_pkt_s;
  logic [7:0]       data_byte_s;

  always_ff @(posedge ipClk or posedge ipReset) begin
    if (ipReset) begin
      state_q    <= P_IDLE;
      is_write_q <= 1'b0;
      addr_q     <= 8'h00;
      wdata_q    <= 8'h00;
      err_q      <= 8'h00;
      wr_en_q    <= 1'b0;
      rd_en_q    <= 1'b0;
      busy_q     <= 1'b0;
      tmo_q      <= '0;
    end else begin
      state_q    <= state_d;
      is_write_q <= is_write_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      err_q      <= err_d;
      wr_en_q    <= wr_en_d;
      rd_en_q    <= rd_en_d;
      busy_q     <= busy_d;
      tmo_q      <= tmo_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    is_write_d  = is_write_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    err_d       = err_q;
    wr_en_d     = 1'b0;
    rd_en_d     = 1'b0;
    tmo_d       = '0;
    start_s     = 1'b0;
    data_byte_s = wdata_q;
    in_pkt_s    = (state_q == P_CMD) || (state_q == P_ADDR) || (state_q == P_DATA);
    case (state_q)
      P_IDLE: begin
        if (ipRxValid && (ipRxData == SYNC_BYTE)) state_d = P_CMD;
        else                                       state_d = P_IDLE;
      end
      P_CMD: begin
        if (ipRxValid) begin
          if ((ipRxData == CMD_READ) || (ipRxData == CMD_WRITE)) begin
            is_write_d = (ipRxData == CMD_WRITE);
            state_d    = P_ADDR;
          end else begin
            err_d   = sat_inc8(err_q);
            state_d = P_IDLE;
          end
        end else begin
          state_d = P_CMD;
        end
      end
      P_ADDR: begin
        if (ipRxValid) begin
          addr_d = ipRxData;
          if (is_write_q) begin
            state_d = P_DATA;
          end else begin
            rd_en_d = 1'b1;
            state_d = P_EXEC;
          end
        end else begin
          state_d = P_ADDR;
        end
      end
      P_DATA: begin
        if (ipRxValid) begin
          wdata_d = ipRxData;
          wr_en_d = 1'b1;
          state_d = P_EXEC;
        end else begin
          state_d = P_DATA;
        end
      end
      P_EXEC: begin
        // A write reply can start now; a read must wait one cycle for bus data
        if (is_write_q) begin
          start_s = 1'b1;
          state_d = P_REPLY;
        end else begin
          state_d = P_RDWAIT;
        end
      end
      P_RDWAIT: begin
        start_s     = 1'b1;
        data_byte_s = ipRegRdData;
        state_d     = P_REPLY;
      end
      P_REPLY: begin
        if (done_s) state_d = P_IDLE;
        else        state_d = P_REPLY;
      end
      default: state_d = P_IDLE;
    endcase

    // Inter-byte timeout; a byte on the expiry cycle wins over the timeout
    if (in_pkt_s) begin
      if (ipRxValid) begin
        tmo_d = '0;
      end else if (tmo_q == TMO_LAST) begin
        err_d   = sat_inc8(err_q);
        state_d = P_IDLE;
      end else begin
        tmo_d = tmo_q + TMO_W'(1);
      end
    end else begin
      tmo_d = '0;
    end

    busy_d = (state_d != P_IDLE);
  end

  uart_reply_sender u_sender (
    .clk     (ipClk),
    .rst     (ipReset),
    .start   (start_s),
    .byte0   (REPLY_BYTE),
    .byte1   (addr_q),
    .byte2   (data_byte_s),
    .tx_busy (ipTxBusy),
    .tx_data (opTxData),
    .tx_send (opTxSend),
    .done    (done_s)
  );

  assign opRegAddr     = addr_q;
  assign opRegWrData   = wdata_q;
  assign opRegWrEnable = wr_en_q;
  assign opRegRdEnable = rd_en_q;
  assign opBusy        = busy_q;
  assign opErrorCount  = err_q;

endmodule
